ioctl_download_driver: RTL and testbench

- Initiator side of the ioctl download bus; drives the emu top's ioctl_download / ioctl_wr / ioctl_addr / ioctl_dout / ioctl_index inputs and honours its ioctl_wait output.
- Pulls bytes from a valid/ready byte source (testbench file reader or HPS shim) and writes them at sequential addresses from 0.
- Frames each transfer with ioctl_download and holds the download flag for a programmable tail, so the core's reset-during-download behaviour is exercised.

---
 rtl/ioctl_download_driver.sv | 155 +++++++++++++++
 tb/tb_ioctl_download_driver.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_download_driver.sv
// Initiator for the ioctl download bus: streams bytes from a valid/ready source
// to sequential addresses, framed by ioctl_download with a programmable tail.
module ioctl_download_driver #(
  parameter int WR_GAP      = 2,
  parameter int TAIL_CYCLES = 16,
  parameter int ADDR_W      = 25
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] length,
  input  logic [7:0]        index,
  input  logic              abort,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  output logic              src_ready,
  output logic              ioctl_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_index,
  input  logic              ioctl_wait,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, GAP, TAIL} state_t;

  localparam int CNT_MAX   = (WR_GAP > TAIL_CYCLES) ? WR_GAP : TAIL_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 2);
  localparam int TAIL_LAST = (TAIL_CYCLES > 0) ? TAIL_CYCLES - 1 : 0;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   len_reg, len_next;
  logic                download_next, wr_next, busy_next, done_next, aborted_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [7:0]          dout_next, index_next;

  assign src_ready = (state_reg == FETCH);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    len_next      = len_reg;
    download_next = ioctl_download;
    wr_next       = 1'b0;
    addr_next     = ioctl_addr;
    dout_next     = ioctl_dout;
    index_next    = ioctl_index;
    done_next     = 1'b0;
    aborted_next  = 1'b0;

    // Abort outranks everything once a transfer is under way, including ioctl_wait.
    if (state_reg != IDLE && abort) begin
      download_next = 1'b0;
      aborted_next  = 1'b1;
      state_next    = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_next = 1'b1;
            end else begin
              len_next      = length;
              index_next    = index;
              addr_next     = '0;
              download_next = 1'b1;
              state_next    = FETCH;
            end
          end
        end
        FETCH: begin
          if (src_valid) begin
            dout_next  = src_data;
            state_next = WRITE;
          end
        end
        WRITE: begin
          if (!ioctl_wait) begin
            wr_next    = 1'b1;
            cnt_next   = '0;
            state_next = GAP;
          end
        end
        GAP: begin
          // First GAP cycle carries the strobe; WR_GAP quiet cycles follow.
          if (cnt_reg == CNT_W'(WR_GAP)) begin
            if (ioctl_addr == len_reg - ADDR_W'(1)) begin
              if (TAIL_CYCLES == 0) begin
                download_next = 1'b0;
                done_next     = 1'b1;
                state_next    = IDLE;
              end else begin
                cnt_next   = '0;
                state_next = TAIL;
              end
            end else begin
              addr_next  = ioctl_addr + ADDR_W'(1);
              state_next = FETCH;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        TAIL: begin
          if (cnt_reg == CNT_W'(TAIL_LAST)) begin
            download_next = 1'b0;
            done_next     = 1'b1;
            state_next    = IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          download_next = 1'b0;
          state_next    = IDLE;
        end
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      len_reg        <= '0;
      ioctl_download <= 1'b0;
      ioctl_wr       <= 1'b0;
      ioctl_addr     <= '0;
      ioctl_dout     <= '0;
      ioctl_index    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      len_reg        <= len_next;
      ioctl_download <= download_next;
      ioctl_wr       <= wr_next;
      ioctl_addr     <= addr_next;
      ioctl_dout     <= dout_next;
      ioctl_index    <= index_next;
      busy           <= busy_next;
      done           <= done_next;
      aborted        <= aborted_next;
    end
  end

endmodule

// File: tb/tb_ioctl_download_driver.sv
// Scoreboard bench for ioctl_download_driver: expected beats are queued with the
// source bytes and compared against strobes captured by a monitor.
module tb_ioctl_download_driver;

  localparam int WR_GAP = 2;
  localparam int TAIL   = 16;
  localparam int AW     = 25;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] length = '0;
  logic [7:0]    index = '0;
  logic          abort = 1'b0;
  logic          src_valid = 1'b0;
  logic [7:0]    src_data = '0;
  logic          src_ready;
  logic          ioctl_download, ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout, ioctl_index;
  logic          ioctl_wait = 1'b0;
  logic          busy, done, aborted;

  ioctl_download_driver #(.WR_GAP(WR_GAP), .TAIL_CYCLES(TAIL), .ADDR_W(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .length(length), .index(index),
    .abort(abort), .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            cyc;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      obs_q[$];
  beat_t      mon_b;
  beat_t      exp_b;
  logic [7:0] src_q[$];
  bit         src_stall = 1'b0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk_sys);
      if (ioctl_wr === 1'b1) begin
        mon_b.addr = ioctl_addr;
        mon_b.data = ioctl_dout;
        mon_b.cyc  = cyc;
        obs_q.push_back(mon_b);
      end
    end
  end

  // Byte source: pops on a completed handshake and presents the queue head.
  initial begin
    bit take;
    forever begin
      @(negedge clk_sys);
      take = src_valid && src_ready && !reset;
      @(posedge clk_sys);
      #1;
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      src_valid = !src_stall && (src_q.size() > 0);
      src_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic push_byte(input logic [AW-1:0] a, input logic [7:0] d, input bit expect_it);
    src_q.push_back(d);
    if (expect_it) begin
      exp_b.addr = a;
      exp_b.data = d;
      exp_b.cyc  = 0;
      exp_q.push_back(exp_b);
    end
  endtask

  task automatic do_start(input logic [AW-1:0] len, input logic [7:0] idx);
    @(posedge clk_sys);
    #1;
    start  = 1'b1;
    length = len;
    index  = idx;
    @(posedge clk_sys);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int limit, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (obs_q.size() >= n) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic settle(input int limit, output int done_cnt, output int fall_cyc);
    done_cnt = 0;
    fall_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
      if (ioctl_download === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, busy, done, aborted, src_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got dl=%b wr=%b addr=%0h dout=%0h idx=%0h busy=%b done=%b ab=%b rdy=%b, want all 0",
               ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, busy, done, aborted, src_ready);
    end
    reset = 1'b0;
    tick();
    $display("reset released");
  endtask

  task automatic test_basic();
    bit to;
    int dcnt, fall;
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 4; i++) push_byte(AW'(i), 8'hA0 + 8'(i), 1'b1);
    do_start(AW'(4), 8'h01);
    wait_strobes(4, 100, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: got %0d strobes, want 4", obs_q.size()); end
    checks++;
    if (ioctl_index !== 8'h01) begin errors++; $display("FAIL basic_index: got %0h want 01", ioctl_index); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin
        errors++; $display("FAIL basic_beat%0d: missing strobe, want addr=%0h data=%0h", i, exp_q[i].addr, exp_q[i].data);
      end else if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++; $display("FAIL basic_beat%0d: got addr=%0h data=%0h, want addr=%0h data=%0h",
                           i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
      end else begin
        $display("basic strobe addr=%0h data=%0h cyc=%0d", obs_q[i].addr, obs_q[i].data, obs_q[i].cyc);
      end
    end
    for (int i = 1; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].cyc - obs_q[i-1].cyc != 3 + WR_GAP) begin
        errors++; $display("FAIL basic_spacing%0d: got %0d cycles, want %0d", i, obs_q[i].cyc - obs_q[i-1].cyc, 3 + WR_GAP);
      end
    end
    settle(40, dcnt, fall);
    checks++;
    if (obs_q.size() < 4 || fall != obs_q[3].cyc + WR_GAP + TAIL + 1) begin
      errors++; $display("FAIL basic_tail: download fell at cyc %0d, want %0d",
                         fall, (obs_q.size() < 4) ? -1 : obs_q[3].cyc + WR_GAP + TAIL + 1);
    end
    checks++;
    if (dcnt != 1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done: got %0d pulses busy=%b, want 1 pulse busy=0", dcnt, busy); end
  endtask

  task automatic test_wait_stall();
    bit to;
    int c, dcnt, fall;
    exp_q.delete();
    obs_q.delete();
    push_byte(AW'(0), 8'h5C, 1'b1);
    push_byte(AW'(1), 8'hE7, 1'b1);
    do_start(AW'(2), 8'h22);
    wait_strobes(1, 50, to);
    for (int i = 0; i < 10 && src_ready !== 1'b1; i++) tick();
    c = cyc;
    ioctl_wait = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (ioctl_wr !== 1'b0 || ioctl_addr !== AW'(1) || ioctl_dout !== 8'hE7) begin
        errors++; $display("FAIL wait_hold%0d: got wr=%b addr=%0h dout=%0h, want wr=0 addr=1 dout=e7", i, ioctl_wr, ioctl_addr, ioctl_dout);
      end
    end
    ioctl_wait = 1'b0;
    tick();
    checks++;
    if (ioctl_wr !== 1'b1 || ioctl_addr !== AW'(1) || ioctl_dout !== 8'hE7 || cyc != c + 9) begin
      errors++; $display("FAIL wait_release: got wr=%b addr=%0h dout=%0h cyc=%0d, want wr=1 addr=1 dout=e7 cyc=%0d",
                         ioctl_wr, ioctl_addr, ioctl_dout, cyc, c + 9);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++; $display("FAIL wait_beat%0d: got %0d strobes, want addr=%0h data=%0h", i, obs_q.size(), exp_q[i].addr, exp_q[i].data);
      end else begin
        $display("wait strobe addr=%0h data=%0h cyc=%0d", obs_q[i].addr, obs_q[i].data, obs_q[i].cyc);
      end
    end
    settle(40, dcnt, fall);
    checks++;
    if (fall != c + 9 + WR_GAP + TAIL + 1 || dcnt != 1) begin
      errors++; $display("FAIL wait_tail: fell at %0d with %0d done, want %0d with 1 done", fall, dcnt, c + 9 + WR_GAP + TAIL + 1);
    end
  endtask

  task automatic test_zero_length();
    do_start(AW'(0), 8'h33);
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ioctl_download !== 1'b0) begin
      errors++; $display("FAIL zero_done: got done=%b busy=%b dl=%b, want 1 0 0", done, busy, ioctl_download);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || ioctl_download !== 1'b0 || ioctl_wr !== 1'b0) begin
        errors++; $display("FAIL zero_quiet%0d: got done=%b busy=%b dl=%b wr=%b, want all 0", i, done, busy, ioctl_download, ioctl_wr);
      end
    end
    $display("zero-length start complete");
  endtask

  task automatic test_starvation();
    bit to;
    int dcnt, fall;
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 6; i++) push_byte(AW'(i), 8'h10 + 8'(i * 3), 1'b1);
    do_start(AW'(6), 8'h44);
    wait_strobes(3, 100, to);
    src_stall = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (obs_q.size() != 3 || src_ready !== 1'b1 || busy !== 1'b1 || ioctl_addr !== AW'(3)) begin
      errors++; $display("FAIL starve_hold: got strobes=%0d rdy=%b busy=%b addr=%0h, want 3 1 1 3", obs_q.size(), src_ready, busy, ioctl_addr);
    end
    src_stall = 1'b0;
    wait_strobes(6, 100, to);
    checks++;
    if (to) begin errors++; $display("FAIL starve_timeout: got %0d strobes, want 6", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++; $display("FAIL starve_beat%0d: got %0d strobes, want addr=%0h data=%0h", i, obs_q.size(), exp_q[i].addr, exp_q[i].data);
      end else begin
        $display("starve strobe addr=%0h data=%0h cyc=%0d", obs_q[i].addr, obs_q[i].data, obs_q[i].cyc);
      end
    end
    settle(40, dcnt, fall);
    checks++;
    if (dcnt != 1 || fall < 0) begin errors++; $display("FAIL starve_done: got %0d done fall=%0d, want 1 done", dcnt, fall); end
  endtask

  task automatic test_abort();
    bit to;
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 100; i++) push_byte(AW'(i), 8'(i * 7 + 1), i < 10);
    do_start(AW'(100), 8'h55);
    wait_strobes(10, 200, to);
    abort = 1'b1;
    @(posedge clk_sys);
    #1;
    abort = 1'b0;
    tick();
    checks++;
    if (aborted !== 1'b1 || ioctl_download !== 1'b0 || ioctl_wr !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_pulse: got ab=%b dl=%b wr=%b busy=%b, want 1 0 0 0", aborted, ioctl_download, ioctl_wr, busy);
    end
    src_q.delete();
    tick();
    checks++;
    if (aborted !== 1'b0) begin errors++; $display("FAIL abort_width: got aborted=%b, want 0", aborted); end
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (obs_q.size() != 10 || done !== 1'b0) begin errors++; $display("FAIL abort_count: got %0d strobes, want 10", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++; $display("FAIL abort_beat%0d: got %0d strobes, want addr=%0h data=%0h", i, obs_q.size(), exp_q[i].addr, exp_q[i].data);
      end
    end
    exp_q.delete();
    obs_q.delete();
    push_byte(AW'(0), 8'hC3, 1'b1);
    do_start(AW'(1), 8'h66);
    wait_strobes(1, 50, to);
    checks++;
    if (to || obs_q[0].addr !== AW'(0) || obs_q[0].data !== 8'hC3 || ioctl_index !== 8'h66) begin
      errors++; $display("FAIL abort_restart: got %0d strobes addr=%0h dout=%0h idx=%0h, want addr=0 dout=c3 idx=66",
                         obs_q.size(), ioctl_addr, ioctl_dout, ioctl_index);
    end else begin
      $display("restart strobe addr=%0h data=%0h", obs_q[0].addr, obs_q[0].data);
    end
    for (int i = 0; i < 30 && busy === 1'b1; i++) tick();
  endtask

  task automatic test_reset_mid_write();
    bit to;
    ioctl_wait = 1'b1;
    for (int i = 0; i < 3; i++) push_byte(AW'(i), 8'h90 + 8'(i), 1'b0);
    do_start(AW'(3), 8'h77);
    for (int i = 0; i < 20 && !(busy === 1'b1 && src_ready === 1'b0); i++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, busy, done, aborted, src_ready} !== '0) begin
      errors++; $display("FAIL reset_async: got dl=%b wr=%b addr=%0h dout=%0h idx=%0h busy=%b rdy=%b, want all 0",
                         ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, busy, src_ready);
    end
    ioctl_wait = 1'b0;
    src_q.delete();
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    push_byte(AW'(0), 8'h3E, 1'b1);
    do_start(AW'(1), 8'h5A);
    wait_strobes(1, 50, to);
    checks++;
    if (to || obs_q[0].addr !== AW'(0) || obs_q[0].data !== 8'h3E || ioctl_index !== 8'h5A) begin
      errors++; $display("FAIL reset_restart: got %0d strobes dout=%0h idx=%0h, want addr=0 dout=3e idx=5a",
                         obs_q.size(), ioctl_dout, ioctl_index);
    end else begin
      $display("post-reset strobe addr=%0h data=%0h", obs_q[0].addr, obs_q[0].data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_stall();
    test_zero_length();
    test_starvation();
    test_abort();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
